wishbone_burst_master: RTL and testbench

WISHBONE_BURST_MASTER -- requirements
Module: wishbone_burst_master

---
 rtl/wishbone_burst_master.sv | 172 +++++++++++++++++
 tb/tb_wishbone_burst_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_burst_master.sv
// Wishbone incrementing-burst master: one command moves 1..2^LEN_W beats over a single cyc/stb window.
// Optional per-beat ack timeout is enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_burst_master #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        bte,
  output logic [2:0]        cti,
  output logic              cyc,
  output logic              stb,
  output logic              we,
  output logic [DATA_W/8-1:0] sel,
  output logic [DATA_W-1:0] data_write,
  input  logic              ack,
  input  logic              err,
  input  logic [DATA_W-1:0] data_read
);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    left_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          bte_q;
  logic [2:0]          cti_q;
  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [DATA_W/8-1:0] sel_q;
  logic [DATA_W-1:0]   data_write_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                done_q;
  logic                error_q;
  logic                timeout_q;

  logic accept;
  logic active;
  logic last;
  logic to_hit;

  assign active = (state_q == ACTIVE);
  assign last   = (left_q == '0);
  // The done cycle is spent in IDLE but must not accept, so back-to-back bursts get one idle gap.
  assign cmd_ready = !reset && (state_q == IDLE) && !done_q;
  assign accept    = cmd_valid && cmd_ready;
  // Show-ahead producer: wr_ready marks the cycle wr_data is captured, so the next beat is popped immediately.
  assign wr_ready  = !reset && ((accept && cmd_we) ||
                                (active && we_q && ack && !err && !last));

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_q;

  always_ff @(posedge clk) begin
    if (reset || !active || ack || err) wait_q <= '0;
    else                                wait_q <= wait_q + CNT_W'(1);
  end

  // wait_q counts completed idle cycles, so the TIMEOUT-th silent cycle is when it equals TIMEOUT-1.
  assign to_hit = active && !ack && !err && (wait_q == CNT_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      left_q       <= '0;
      addr_q       <= '0;
      bte_q        <= '0;
      cti_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      data_write_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= ACTIVE;
            left_q  <= cmd_len;
            addr_q  <= cmd_addr;
            bte_q   <= 2'b00;
            cti_q   <= (cmd_len == '0) ? CTI_END : CTI_INCR;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= cmd_we;
            sel_q   <= '1;
            if (cmd_we) data_write_q <= wr_data;
          end
        end
        ACTIVE: begin
          if (err || to_hit) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            sel_q     <= '0;
            done_q    <= 1'b1;
            error_q   <= 1'b1;
            timeout_q <= to_hit;
          end else if (ack) begin
            if (!we_q) begin
              rd_data_q  <= data_read;
              rd_valid_q <= 1'b1;
            end
            if (last) begin
              state_q <= IDLE;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              sel_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              left_q <= left_q - LEN_W'(1);
              addr_q <= addr_q + ADDR_W'(1);
              cti_q  <= (left_q == LEN_W'(1)) ? CTI_END : CTI_INCR;
              if (we_q) data_write_q <= wr_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = active;
  assign addr       = addr_q;
  assign bte        = bte_q;
  assign cti        = cti_q;
  assign cyc        = cyc_q;
  assign stb        = stb_q;
  assign we         = we_q;
  assign sel        = sel_q;
  assign data_write = data_write_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign error      = error_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Directed bench for wishbone_burst_master: reads, writes, address wrap, bus error, ack timeout, mid-burst reset.
module tb_wishbone_burst_master;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              error;
  logic              timeout;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bte;
  logic [2:0]        cti;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0] data_write;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] data_read;

  int total = 0;
  int bad   = 0;
  int pulses;

  wishbone_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error), .timeout(timeout),
    .busy(busy), .addr(addr), .bte(bte), .cti(cti), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
    .data_write(data_write), .ack(ack), .err(err), .data_read(data_read)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_len = l;
    settle();
    check_eq("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; ack = 1'b0; err = 1'b0; data_read = '0;
    step(); step(); settle();
    check_eq("rst_cyc", cyc, 1'b0);
    check_eq("rst_stb", stb, 1'b0);
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_outs", {addr, bte, cti, we, sel, data_write, rd_data}, '0);
    check_eq("rst_pulses", {wr_ready, rd_valid, done, error, timeout}, 5'b0);
    reset = 1'b0;
    step(); settle();
    check_eq("cmd_ready_after_rst", cmd_ready, 1'b1);

    // ack/err while idle are ignored
    ack = 1'b1; err = 1'b1;
    step(); ack = 1'b0; err = 1'b0; settle();
    check_eq("idle_ignore", {cyc, done, error, rd_valid, busy}, 5'b0);

    // 4-beat read at 0x100 with ack every cycle
    issue(1'b0, 30'h100, 4'd3);
    settle();
    check_eq("rd_start_bus", {cyc, stb, we, sel, bte, busy}, {1'b1, 1'b1, 1'b0, 4'hF, 2'b00, 1'b1});
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; data_read = 32'hA000_0000 + 32'(i);
      settle();
      check_eq($sformatf("rd_addr%0d", i), addr, 30'h100 + 30'(i));
      check_eq($sformatf("rd_cti%0d", i), cti, (i == 3) ? 3'b111 : 3'b010);
      check_eq($sformatf("rd_valid%0d", i), rd_valid, (i > 0) ? 1'b1 : 1'b0);
      if (i > 0) check_eq($sformatf("rd_data%0d", i - 1), rd_data, 32'hA000_0000 + 32'(i - 1));
      check_eq($sformatf("rd_done_early%0d", i), done, 1'b0);
      step();
    end
    ack = 1'b0; settle();
    check_eq("rd_end_cyc", {cyc, stb, sel}, 6'b0);
    check_eq("rd_done_err", {done, error, timeout}, 3'b100);
    check_eq("rd_last_valid", {rd_valid, rd_data}, {1'b1, 32'hA000_0003});
    check_eq("rd_no_accept_on_done", cmd_ready, 1'b0);
    step(); settle();
    check_eq("rd_done_single", {done, rd_valid, cmd_ready}, 3'b001);

    // 1-beat write, slave waits 3 cycles before ack
    wr_data = 32'hDEAD_BEEF;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 30'h20; cmd_len = 4'd0;
    settle();
    check_eq("wr1_ready_accept", wr_ready, 1'b1);
    step(); cmd_valid = 1'b0; wr_data = 32'h1111_1111; settle();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      ack = (i == 3);
      settle();
      check_eq($sformatf("wr1_bus%0d", i), {cyc, stb, we, cti}, {1'b1, 1'b1, 1'b1, 3'b111});
      check_eq($sformatf("wr1_data%0d", i), data_write, 32'hDEAD_BEEF);
      if (wr_ready) pulses++;
      step();
    end
    ack = 1'b0; settle();
    check_eq("wr1_extra_wr_ready", pulses, 0);
    check_eq("wr1_end", {cyc, stb, done, error}, 4'b0010);

    // 3-beat read that wraps the address
    step();
    issue(1'b0, 30'h3FFF_FFFF, 4'd2);
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1; settle();
      check_eq($sformatf("wrap_addr%0d", i), addr, (i == 0) ? 30'h3FFF_FFFF : 30'(i - 1));
      step();
    end
    ack = 1'b0; settle();
    check_eq("wrap_done", done, 1'b1);

    // 8-beat write, err together with ack on the third beat
    step();
    wr_data = 32'hC0DE_0000;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 30'h40; cmd_len = 4'd7;
    settle();
    check_eq("err_accept_wr_ready", wr_ready, 1'b1);
    step(); cmd_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("err_dw%0d", i), data_write, 32'hC0DE_0000 + 32'(i));
      wr_data = 32'hC0DE_0000 + 32'(i + 1);
      ack = 1'b1; err = (i == 2);
      settle();
      check_eq($sformatf("err_wr_ready%0d", i), wr_ready, (i < 2) ? 1'b1 : 1'b0);
      if (wr_ready) pulses++;
      step();
    end
    ack = 1'b0; err = 1'b0; settle();
    check_eq("err_beats", pulses, 2);
    check_eq("err_end", {cyc, stb, busy, done, error, timeout, rd_valid}, 7'b0001100);

    // Slave never acks
    step();
    issue(1'b0, 30'h80, 4'd0);
`ifdef WB_MASTER_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      settle();
      check_eq($sformatf("to_hold%0d", k), {cyc, done}, 2'b10);
      step();
    end
    settle();
    check_eq("to_abort", {cyc, stb, done, error, timeout}, 5'b00111);
`else
    for (int k = 0; k < 40; k++) begin
      settle();
      if (k % 8 == 0) check_eq($sformatf("noto_hold%0d", k), {cyc, stb, done, timeout}, 4'b1100);
      step();
    end
    ack = 1'b1; settle(); step(); ack = 1'b0; settle();
    check_eq("noto_finish", {cyc, done, error, timeout}, 4'b0100);
`endif

    // Reset during beat 2 of a 4-beat read
    step(); step();
    issue(1'b0, 30'h200, 4'd3);
    ack = 1'b1; step();
    reset = 1'b1; settle();
    check_eq("rst_mid_active", cyc, 1'b1);
    step(); ack = 1'b0; settle();
    check_eq("rst_mid_drop", {cyc, stb, busy, done, rd_valid}, 5'b0);
    reset = 1'b0;
    step(); settle();
    check_eq("rst_mid_after", {cmd_ready, done}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
